// File: rtl/counter_range_monitor.sv
// counter_range_monitor: checks a bounded LO..HI up/down counter stream for legal steps, wraps and range.
module counter_range_monitor #(
    parameter int WIDTH  = 8,
    parameter int LO     = 10,
    parameter int HI     = 40,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              load_in,
    input  logic              clr,
    output logic              dir_up,
    output logic              dir_down,
    output logic              wrap_p,
    output logic              err_step,
    output logic              err_range,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {EMPTY = 3'd0, HOLD = 3'd1, UP = 3'd2, DOWN = 3'd3, ERR = 3'd4} state_t;

    localparam logic [WIDTH:0] LO_X = (WIDTH+1)'(LO);
    localparam logic [WIDTH:0] HI_X = (WIDTH+1)'(HI);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic              dir_up_q, dir_up_d, dir_down_q, dir_down_d, wrap_p_q, wrap_p_d;
    logic              err_step_q, err_step_d, err_range_q, err_range_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [WIDTH:0]    cur_x, prev_x;
    logic              in_range, wrap;

    // One extra bit keeps prev+1 / prev-1 from aliasing at the ends of the WIDTH range
    assign cur_x    = {1'b0, count_in};
    assign prev_x   = {1'b0, prev_q};
    assign in_range = (cur_x >= LO_X) && (cur_x <= HI_X);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_up_d    = dir_up_q;
        dir_down_d  = dir_down_q;
        wrap_p_d    = 1'b0;
        err_step_d  = err_step_q;
        err_range_d = err_range_q;
        wrap_cnt_d  = wrap_cnt_q;
        wrap        = 1'b0;
        if (clr) begin
            state_d     = EMPTY;
            prev_d      = '0;
            dir_up_d    = 1'b0;
            dir_down_d  = 1'b0;
            err_step_d  = 1'b0;
            err_range_d = 1'b0;
            wrap_cnt_d  = '0;
        end else if (valid && state_q == EMPTY) begin
            prev_d      = count_in;
            state_d     = in_range ? HOLD : ERR;
            err_range_d = !in_range;
        end else if (valid && state_q != ERR) begin
            if (!in_range) begin
                state_d     = ERR;
                err_range_d = 1'b1;
            end else begin
                prev_d = count_in;
                if (load_in) begin
                    state_d    = HOLD;
                    dir_up_d   = 1'b0;
                    dir_down_d = 1'b0;
                end else if (cur_x == prev_x) begin
                    state_d = state_q;
                end else if (prev_x < HI_X && cur_x == prev_x + 1'b1) begin
                    state_d    = UP;
                    dir_up_d   = 1'b1;
                    dir_down_d = 1'b0;
                end else if (prev_x > LO_X && cur_x == prev_x - 1'b1) begin
                    state_d    = DOWN;
                    dir_up_d   = 1'b0;
                    dir_down_d = 1'b1;
                end else if (prev_x == HI_X && cur_x == LO_X) begin
                    state_d    = UP;
                    dir_up_d   = 1'b1;
                    dir_down_d = 1'b0;
                    wrap       = 1'b1;
                end else if (prev_x == LO_X && cur_x == HI_X) begin
                    state_d    = DOWN;
                    dir_up_d   = 1'b0;
                    dir_down_d = 1'b1;
                    wrap       = 1'b1;
                end else begin
                    state_d    = ERR;
                    err_step_d = 1'b1;
                end
            end
        end
        if (wrap) begin
            wrap_p_d   = 1'b1;
            wrap_cnt_d = (&wrap_cnt_q) ? wrap_cnt_q : wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            prev_q      <= '0;
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
            wrap_p_q    <= 1'b0;
            err_step_q  <= 1'b0;
            err_range_q <= 1'b0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dir_up_q    <= dir_up_d;
            dir_down_q  <= dir_down_d;
            wrap_p_q    <= wrap_p_d;
            err_step_q  <= err_step_d;
            err_range_q <= err_range_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign dir_up    = dir_up_q;
    assign dir_down  = dir_down_q;
    assign wrap_p    = wrap_p_q;
    assign err_step  = err_step_q;
    assign err_range = err_range_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign state     = state_q;
endmodule

// File: tb/tb_counter_range_monitor.sv
// tb_counter_range_monitor: directed and randomized checks of counter_range_monitor against a rule-level model.
module tb_counter_range_monitor;
    localparam int LO = 10;
    localparam int HI = 40;
    localparam int WMAX = 255;

    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, load_in = 1'b0, clr = 1'b0;
    logic [7:0] count_in = '0;
    logic       dir_up, dir_down, wrap_p, err_step, err_range;
    logic [7:0] wrap_cnt;
    logic [2:0] state;

    int chk = 0, errs = 0;
    int m_state, m_prev, m_wc;
    bit m_up, m_dn, m_wp, m_es, m_er;

    counter_range_monitor #(.WIDTH(8), .LO(LO), .HI(HI), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .count_in(count_in), .load_in(load_in), .clr(clr),
        .dir_up(dir_up), .dir_down(dir_down), .wrap_p(wrap_p), .err_step(err_step),
        .err_range(err_range), .wrap_cnt(wrap_cnt), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_v();
        return {state, dir_up, dir_down, wrap_p, err_step, err_range, wrap_cnt};
    endfunction

    function automatic logic [15:0] mdl_v();
        return {3'(m_state), m_up, m_dn, m_wp, m_es, m_er, 8'(m_wc)};
    endfunction

    function automatic void model_clear();
        m_state = 0; m_prev = 0; m_wc = 0;
        m_up = 0; m_dn = 0; m_wp = 0; m_es = 0; m_er = 0;
    endfunction

    function automatic void model_step(bit v, int cur, bit ld, bit cl);
        int old;
        bit ok;
        m_wp = 0;
        ok = (cur >= LO) && (cur <= HI);
        if (cl) begin
            model_clear();
            return;
        end
        if (!v || m_state == 4) return;
        if (m_state == 0) begin
            m_prev = cur;
            m_state = ok ? 1 : 4;
            m_er = !ok;
            return;
        end
        if (!ok) begin
            m_er = 1; m_state = 4;
            return;
        end
        old = m_prev;
        m_prev = cur;
        if (ld) begin
            m_state = 1; m_up = 0; m_dn = 0;
        end else if (cur == old) begin
        end else if ((old < HI && cur == old + 1) || (old == HI && cur == LO)) begin
            m_state = 2; m_up = 1; m_dn = 0;
            if (old == HI) begin m_wp = 1; if (m_wc < WMAX) m_wc++; end
        end else if ((old > LO && cur == old - 1) || (old == LO && cur == HI)) begin
            m_state = 3; m_up = 0; m_dn = 1;
            if (old == LO) begin m_wp = 1; if (m_wc < WMAX) m_wc++; end
        end else begin
            m_es = 1; m_state = 4;
        end
    endfunction

    task automatic drive(bit v, int c, bit ld, bit cl);
        @(negedge clk);
        valid = v; count_in = 8'(c); load_in = ld; clr = cl;
        @(posedge clk);
        #1;
        model_step(v, c, ld, cl);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1 model_clear();
        chk++;
        if (dut_v() !== 16'h0) begin errs++; $display("FAIL reset: got %h exp 0000", dut_v()); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        int seq[3] = '{10, 11, 12};
        int exp_st[3] = '{1, 2, 2};
        foreach (seq[i]) begin
            drive(1, seq[i], 0, 0);
            chk++;
            if (dut_v() !== mdl_v() || state !== 3'(exp_st[i])) begin
                errs++; $display("FAIL count_up[%0d]: got %h exp %h", i, dut_v(), mdl_v());
            end
        end
        chk++;
        if (dir_up !== 1'b1 || err_step !== 1'b0 || err_range !== 1'b0) begin
            errs++; $display("FAIL count_up_flags: got up=%b es=%b er=%b exp 1 0 0", dir_up, err_step, err_range);
        end
    endtask

    task automatic test_up_wrap();
        drive(0, 0, 0, 1);
        drive(1, 39, 0, 0);
        drive(1, 40, 0, 0);
        chk++;
        if (wrap_p !== 1'b0) begin errs++; $display("FAIL up_wrap_early: got wrap_p=%b exp 0", wrap_p); end
        drive(1, 10, 0, 0);
        chk++;
        if (wrap_p !== 1'b1 || wrap_cnt !== 8'd1 || state !== 3'd2 || dut_v() !== mdl_v()) begin
            errs++; $display("FAIL up_wrap: got %h exp %h", dut_v(), mdl_v());
        end
        drive(0, 0, 0, 0);
        chk++;
        if (wrap_p !== 1'b0 || wrap_cnt !== 8'd1) begin
            errs++; $display("FAIL up_wrap_pulse: got wrap_p=%b cnt=%0d exp 0 1", wrap_p, wrap_cnt);
        end
    endtask

    task automatic test_down_wrap();
        int seq[4] = '{11, 10, 40, 39};
        drive(0, 0, 0, 1);
        foreach (seq[i]) begin
            drive(1, seq[i], 0, 0);
            chk++;
            if (dut_v() !== mdl_v() || wrap_p !== (i == 2)) begin
                errs++; $display("FAIL down_wrap[%0d]: got %h exp %h", i, dut_v(), mdl_v());
            end
        end
        chk++;
        if (dir_down !== 1'b1 || dir_up !== 1'b0 || wrap_cnt !== 8'd1 || state !== 3'd3) begin
            errs++; $display("FAIL down_wrap_end: got %h exp dn=1 cnt=1 st=3", dut_v());
        end
    endtask

    task automatic test_step_error();
        drive(0, 0, 0, 1);
        drive(1, 20, 0, 0);
        drive(1, 25, 0, 0);
        chk++;
        if (err_step !== 1'b1 || state !== 3'd4) begin
            errs++; $display("FAIL step_err: got es=%b st=%0d exp 1 4", err_step, state);
        end
        drive(1, 26, 0, 0);
        drive(1, 200, 0, 0);
        chk++;
        if (dut_v() !== mdl_v() || err_range !== 1'b0 || state !== 3'd4) begin
            errs++; $display("FAIL err_sticky: got %h exp %h", dut_v(), mdl_v());
        end
        drive(1, 21, 0, 1);
        chk++;
        if (dut_v() !== 16'h0) begin errs++; $display("FAIL clr_over_valid: got %h exp 0000", dut_v()); end
    endtask

    task automatic test_load();
        drive(1, 20, 0, 0);
        drive(1, 25, 1, 0);
        chk++;
        if (state !== 3'd1 || err_step !== 1'b0 || dut_v() !== mdl_v()) begin
            errs++; $display("FAIL load: got %h exp %h", dut_v(), mdl_v());
        end
        drive(1, 9, 0, 0);
        chk++;
        if (err_range !== 1'b1 || state !== 3'd4) begin
            errs++; $display("FAIL range_low: got er=%b st=%0d exp 1 4", err_range, state);
        end
        drive(0, 0, 0, 1);
        drive(1, 255, 0, 0);
        chk++;
        if (err_range !== 1'b1 || state !== 3'd4 || dut_v() !== mdl_v()) begin
            errs++; $display("FAIL range_first: got %h exp %h", dut_v(), mdl_v());
        end
        drive(0, 0, 0, 1);
        drive(1, 40, 0, 0);
        drive(1, 41, 0, 0);
        chk++;
        if (err_range !== 1'b1 || err_step !== 1'b0) begin
            errs++; $display("FAIL range_high: got er=%b es=%b exp 1 0", err_range, err_step);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 1);
        drive(1, 29, 0, 0);
        drive(1, 30, 0, 0);
        #2 rst = 1'b0;
        #1 model_clear();
        chk++;
        if (dut_v() !== 16'h0) begin errs++; $display("FAIL async_rst: got %h exp 0000", dut_v()); end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 30, 0, 0);
        chk++;
        if (state !== 3'd1 || err_step !== 1'b0 || err_range !== 1'b0 || dut_v() !== mdl_v()) begin
            errs++; $display("FAIL async_rst_resume: got %h exp %h", dut_v(), mdl_v());
        end
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 1);
        drive(1, 40, 0, 0);
        for (int i = 0; i < 300; i++) begin
            drive(1, (i % 2 == 0) ? LO : HI, 0, 0);
            if (i > 250) begin
                chk++;
                if (dut_v() !== mdl_v() || wrap_p !== 1'b1) begin
                    errs++; $display("FAIL saturate[%0d]: got %h exp %h", i, dut_v(), mdl_v());
                end
            end
        end
        chk++;
        if (wrap_cnt !== 8'd255) begin errs++; $display("FAIL saturate_cnt: got %0d exp 255", wrap_cnt); end
    endtask

    task automatic test_random();
        int c, r;
        bit v, ld, cl;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 19);
            v  = ($urandom_range(0, 9) < 8);
            ld = ($urandom_range(0, 29) == 0);
            cl = ($urandom_range(0, 39) == 0);
            c  = (r < 6)  ? m_prev + 1 :
                 (r < 10) ? m_prev - 1 :
                 (r < 11) ? m_prev :
                 (r < 13) ? ((m_prev == HI) ? LO : HI) :
                 (r < 15) ? ((m_prev == LO) ? HI : LO) :
                 (r < 18) ? $urandom_range(LO, HI) : $urandom_range(0, 255);
            c &= 255;
            drive(v, c, ld, cl);
            chk++;
            if (dut_v() !== mdl_v()) begin
                errs++; $display("FAIL random[%0d]: got %h exp %h", i, dut_v(), mdl_v());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_count_up();
        test_up_wrap();
        test_down_wrap();
        test_step_error();
        test_load();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end
endmodule
